// File: rtl/dcache_set_assoc.sv
// Write-back, write-allocate N-way (1 or 2) set-associative data cache with per-set LRU and saturating hit/miss counters.
// Hits complete in the same cycle; a miss stalls the CPU via BUSYWAIT_OUT through optional writeback, allocate and one refill cycle.
module dcache_set_assoc #(
    parameter  int ADDR_WIDTH  = 8,
    parameter  int BLOCK_BYTES = 4,
    parameter  int SETS        = 4,
    parameter  int WAYS        = 2,
    parameter  int CNT_WIDTH   = 16,
    localparam int OB          = $clog2(BLOCK_BYTES),
    localparam int IB          = $clog2(SETS),
    localparam int TW          = ADDR_WIDTH - OB - IB,
    localparam int BW          = 8 * BLOCK_BYTES
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     READ_IN,
    input  logic                     WRITE_IN,
    input  logic [ADDR_WIDTH-1:0]    ADDRESS_IN,
    input  logic [7:0]               WRITEDATA_IN,
    output logic [7:0]               READDATA_OUT,
    output logic                     BUSYWAIT_OUT,
    output logic                     READ_OUT,
    output logic                     WRITE_OUT,
    output logic [ADDR_WIDTH-OB-1:0] ADDRESS_OUT,
    output logic [BW-1:0]            WRITEDATA_OUT,
    input  logic [BW-1:0]            READDATA_IN,
    input  logic                     BUSYWAIT_IN,
    output logic [CNT_WIDTH-1:0]     HIT_COUNT,
    output logic [CNT_WIDTH-1:0]     MISS_COUNT
);
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

    state_t               state_q, state_d;
    logic                 valid_q [WAYS][SETS];
    logic                 dirty_q [WAYS][SETS];
    logic [TW-1:0]        tag_q   [WAYS][SETS];
    logic [BW-1:0]        data_q  [WAYS][SETS];
    logic [SETS-1:0]      lru_q;
    logic                 victim_q, victim_d;
    logic                 first_q;
    logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q;

    logic [OB-1:0] offset;
    logic [IB-1:0] idx;
    logic [TW-1:0] tag;
    logic          req, way_match, hit, hit_way, victim_sel;
    logic [BW-1:0] hit_line, merged_line;

    assign offset = ADDRESS_IN[OB-1:0];
    assign idx    = ADDRESS_IN[OB+IB-1:OB];
    assign tag    = ADDRESS_IN[ADDR_WIDTH-1:OB+IB];
    assign req    = READ_IN | WRITE_IN;

    // Victim prefers the lowest-index invalid way; otherwise the set's LRU way.
    always_comb begin
        way_match  = 1'b0;
        hit_way    = 1'b0;
        victim_sel = (WAYS > 1) ? lru_q[idx] : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][idx]) victim_sel = w[0];
            if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
                way_match = 1'b1;
                hit_way   = w[0];
            end
        end
    end

    assign hit      = req & way_match;
    assign hit_line = data_q[hit_way][idx];
    assign victim_d = (state_q == IDLE) ? victim_sel : victim_q;

    always_comb begin
        merged_line = hit_line;
        merged_line[{offset, 3'b000} +: 8] = WRITEDATA_IN;
    end

    assign READDATA_OUT  = (state_q == IDLE && hit && !WRITE_IN) ? hit_line[{offset, 3'b000} +: 8] : 8'h00;
    assign ADDRESS_OUT   = (state_q == WRITEBACK) ? {tag_q[victim_q][idx], idx}
                                                  : ADDRESS_IN[ADDR_WIDTH-1:OB];
    assign WRITEDATA_OUT = data_q[victim_q][idx];
    assign HIT_COUNT     = hit_cnt_q;
    assign MISS_COUNT    = miss_cnt_q;

    always_comb begin
        state_d      = state_q;
        BUSYWAIT_OUT = 1'b0;
        READ_OUT     = 1'b0;
        WRITE_OUT    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    BUSYWAIT_OUT = 1'b1;
                    state_d = (valid_q[victim_sel][idx] && dirty_q[victim_sel][idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                BUSYWAIT_OUT = 1'b1;
                WRITE_OUT    = 1'b1;
                if (!BUSYWAIT_IN) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                BUSYWAIT_OUT = 1'b1;
                READ_OUT     = 1'b1;
                if (!BUSYWAIT_IN) state_d = REFILL;
            end
            REFILL: begin
                BUSYWAIT_OUT = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= IDLE;
            victim_q   <= 1'b0;
            first_q    <= 1'b0;
            lru_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            case (state_q)
                IDLE: begin
                    first_q <= 1'b0;
                    if (hit) begin
                        if (WAYS > 1) lru_q[idx] <= ~hit_way;
                        if (WRITE_IN) begin
                            data_q[hit_way][idx]  <= merged_line;
                            dirty_q[hit_way][idx] <= 1'b1;
                        end
                        // The access completing a refill was already counted as a miss.
                        if (!first_q && hit_cnt_q != {CNT_WIDTH{1'b1}})
                            hit_cnt_q <= hit_cnt_q + 1'b1;
                    end else if (req && miss_cnt_q != {CNT_WIDTH{1'b1}}) begin
                        miss_cnt_q <= miss_cnt_q + 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (!BUSYWAIT_IN) begin
                        data_q[victim_q][idx]  <= READDATA_IN;
                        tag_q[victim_q][idx]   <= tag;
                        valid_q[victim_q][idx] <= 1'b1;
                        dirty_q[victim_q][idx] <= 1'b0;
                    end
                end
                REFILL:  first_q <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_set_assoc.sv
// Directed bench: a 2-way/16-bit-counter cache and a 1-way/2-bit-counter cache, each with a 5-cycle block memory model.
module tb_dcache_set_assoc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_i   [2];
    logic        wr_i   [2];
    logic [7:0]  addr_i [2];
    logic [7:0]  wdat_i [2];
    logic [7:0]  rdat_o [2];
    logic        busy_o [2];
    logic        mrd_o  [2];
    logic        mwr_o  [2];
    logic [5:0]  maddr_o[2];
    logic [31:0] mwdat_o[2];
    logic [31:0] mrdat_i[2];
    logic        mbusy_i[2];
    logic [15:0] hit0, miss0;
    logic [1:0]  hit1, miss1;

    dcache_set_assoc #(.ADDR_WIDTH(8), .BLOCK_BYTES(4), .SETS(4), .WAYS(2), .CNT_WIDTH(16)) u_dut0 (
        .CLOCK(clk), .RESET(rst), .READ_IN(rd_i[0]), .WRITE_IN(wr_i[0]), .ADDRESS_IN(addr_i[0]),
        .WRITEDATA_IN(wdat_i[0]), .READDATA_OUT(rdat_o[0]), .BUSYWAIT_OUT(busy_o[0]),
        .READ_OUT(mrd_o[0]), .WRITE_OUT(mwr_o[0]), .ADDRESS_OUT(maddr_o[0]),
        .WRITEDATA_OUT(mwdat_o[0]), .READDATA_IN(mrdat_i[0]), .BUSYWAIT_IN(mbusy_i[0]),
        .HIT_COUNT(hit0), .MISS_COUNT(miss0));

    dcache_set_assoc #(.ADDR_WIDTH(8), .BLOCK_BYTES(4), .SETS(4), .WAYS(1), .CNT_WIDTH(2)) u_dut1 (
        .CLOCK(clk), .RESET(rst), .READ_IN(rd_i[1]), .WRITE_IN(wr_i[1]), .ADDRESS_IN(addr_i[1]),
        .WRITEDATA_IN(wdat_i[1]), .READDATA_OUT(rdat_o[1]), .BUSYWAIT_OUT(busy_o[1]),
        .READ_OUT(mrd_o[1]), .WRITE_OUT(mwr_o[1]), .ADDRESS_OUT(maddr_o[1]),
        .WRITEDATA_OUT(mwdat_o[1]), .READDATA_IN(mrdat_i[1]), .BUSYWAIT_IN(mbusy_i[1]),
        .HIT_COUNT(hit1), .MISS_COUNT(miss1));

    // Memory model: busy from the first request cycle for 5 cycles, completes on the 6th edge.
    logic [31:0] mem [2][64];
    int          mcnt[2];
    logic        mem_init;

    assign mbusy_i[0] = (mrd_o[0] | mwr_o[0]) && (mcnt[0] < 5);
    assign mbusy_i[1] = (mrd_o[1] | mwr_o[1]) && (mcnt[1] < 5);
    assign mrdat_i[0] = mem[0][maddr_o[0]];
    assign mrdat_i[1] = mem[1][maddr_o[1]];

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mem_init) begin
                for (int i = 0; i < 64; i++) mem[g][i] <= 32'h44332211 + i * 32'h01010101;
            end
            if (rst || !(mrd_o[g] || mwr_o[g])) begin
                mcnt[g] <= 0;
            end else if (mcnt[g] == 5) begin
                mcnt[g] <= 0;
                if (mwr_o[g]) mem[g][maddr_o[g]] <= mwdat_o[g];
            end else begin
                mcnt[g] <= mcnt[g] + 1;
            end
        end
    end

    logic        saw_rd [2];
    logic        saw_wr [2];
    logic [5:0]  rd_addr[2];
    logic [5:0]  wb_addr[2];
    logic [31:0] wb_dat [2];
    int          both_hi = 0;

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mrd_o[g]) begin saw_rd[g] = 1'b1; rd_addr[g] = maddr_o[g]; end
            if (mwr_o[g]) begin saw_wr[g] = 1'b1; wb_addr[g] = maddr_o[g]; wb_dat[g] = mwdat_o[g]; end
            if (mrd_o[g] && mwr_o[g]) both_hi++;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Called at a falling edge; holds the request until the stall clears, then one more edge.
    task automatic acc(input int d, input bit w, input logic [7:0] a, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input int exp_cyc);
        int cyc;
        saw_rd[d] = 1'b0;
        saw_wr[d] = 1'b0;
        rd_i[d] = !w; wr_i[d] = w; addr_i[d] = a; wdat_i[d] = wd;
        cyc = 0;
        #1;
        while (busy_o[d] && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk($sformatf("d%0d@%h stall_end", d, a), {31'd0, busy_o[d]}, 32'd0);
        chk($sformatf("d%0d@%h stall_cycles", d, a), cyc, exp_cyc);
        if (!w) chk($sformatf("d%0d@%h rdata", d, a), {24'd0, rdat_o[d]}, {24'd0, exp_rd});
        @(negedge clk);
        rd_i[d] = 1'b0; wr_i[d] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        for (int g = 0; g < 2; g++) begin
            rd_i[g] = 1'b0; wr_i[g] = 1'b0; addr_i[g] = 8'h00; wdat_i[g] = 8'h00;
            saw_rd[g] = 1'b0; saw_wr[g] = 1'b0;
            rd_addr[g] = '0; wb_addr[g] = '0; wb_dat[g] = '0;
        end
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst busywait", {31'd0, busy_o[0]}, 32'd0);
        chk("rst read_out", {31'd0, mrd_o[0]}, 32'd0);
        chk("rst write_out", {31'd0, mwr_o[0]}, 32'd0);
        chk("rst readdata", {24'd0, rdat_o[0]}, 32'd0);
        chk("rst hits", {16'd0, hit0}, 32'd0);
        chk("rst misses", {16'd0, miss0}, 32'd0);
        @(negedge clk);

        // Cold read miss, then a same-block hit
        acc(0, 0, 8'h00, 8'h00, 8'h11, 8);
        chk("t1 read_out seen", {31'd0, saw_rd[0]}, 32'd1);
        chk("t1 fetch addr", {26'd0, rd_addr[0]}, 32'h00);
        chk("t1 no writeback", {31'd0, saw_wr[0]}, 32'd0);
        chk("t1 misses", {16'd0, miss0}, 32'd1);
        chk("t1 hits after refill", {16'd0, hit0}, 32'd0);
        acc(0, 0, 8'h03, 8'h00, 8'h44, 0);
        chk("t1 hits", {16'd0, hit0}, 32'd1);

        // Write hit stays in the cache
        acc(0, 1, 8'h01, 8'hAB, 8'h00, 0);
        chk("t2 no mem traffic", {30'd0, saw_rd[0], saw_wr[0]}, 32'd0);
        acc(0, 0, 8'h01, 8'h00, 8'hAB, 0);
        chk("t2 hits", {16'd0, hit0}, 32'd3);

        // Clean eviction of the LRU way
        acc(0, 0, 8'h10, 8'h00, 8'h15, 8);
        acc(0, 0, 8'h00, 8'h00, 8'h11, 0);
        acc(0, 0, 8'h20, 8'h00, 8'h19, 8);
        chk("t3 clean evict no wb", {31'd0, saw_wr[0]}, 32'd0);
        chk("t3 fetch addr", {26'd0, rd_addr[0]}, 32'h08);
        acc(0, 0, 8'h00, 8'h00, 8'h11, 0);
        chk("t3 misses", {16'd0, miss0}, 32'd3);
        chk("t3 hits", {16'd0, hit0}, 32'd5);

        // Dirty eviction writes the block back before the fetch
        acc(0, 1, 8'h10, 8'h5A, 8'h00, 8);
        acc(0, 0, 8'h00, 8'h00, 8'h11, 0);
        acc(0, 0, 8'h20, 8'h00, 8'h19, 14);
        chk("t4 writeback seen", {31'd0, saw_wr[0]}, 32'd1);
        chk("t4 wb addr", {26'd0, wb_addr[0]}, 32'h04);
        chk("t4 wb byte0", {24'd0, wb_dat[0][7:0]}, 32'h5A);
        chk("t4 fetch addr", {26'd0, rd_addr[0]}, 32'h08);
        acc(0, 0, 8'h10, 8'h00, 8'h5A, 14);
        chk("t4 wb2 addr", {26'd0, wb_addr[0]}, 32'h00);
        chk("t4 wb2 byte1", {24'd0, wb_dat[0][15:8]}, 32'hAB);
        chk("t4 misses", {16'd0, miss0}, 32'd6);
        chk("t4 hits", {16'd0, hit0}, 32'd6);

        // Reset in the middle of an allocate
        rd_i[0] = 1'b1; addr_i[0] = 8'h30;
        repeat (3) @(negedge clk);
        #1;
        chk("t5 allocating", {31'd0, mrd_o[0]}, 32'd1);
        rst = 1'b1; rd_i[0] = 1'b0;
        @(negedge clk);
        #1;
        chk("t5 read_out dropped", {31'd0, mrd_o[0]}, 32'd0);
        chk("t5 busywait dropped", {31'd0, busy_o[0]}, 32'd0);
        chk("t5 hits cleared", {16'd0, hit0}, 32'd0);
        chk("t5 misses cleared", {16'd0, miss0}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        acc(0, 0, 8'h30, 8'h00, 8'h1D, 8);
        chk("t5 reread misses", {16'd0, miss0}, 32'd1);

        // Narrow counters saturate; a direct-mapped set thrashes
        acc(1, 0, 8'h00, 8'h00, 8'h11, 8);
        for (int i = 0; i < 5; i++) acc(1, 0, 8'h01, 8'h00, 8'h22, 0);
        chk("t6 hits saturate", {30'd0, hit1}, 32'd3);
        acc(1, 0, 8'h10, 8'h00, 8'h15, 8);
        acc(1, 0, 8'h00, 8'h00, 8'h11, 8);
        acc(1, 0, 8'h10, 8'h00, 8'h15, 8);
        chk("t6 misses saturate", {30'd0, miss1}, 32'd3);

        chk("rd/wr never both high", both_hi, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
